// File: rtl/acc_drain_pkg.sv
// Shared types and constants for the accumulator drain block.
package acc_drain_pkg;
  localparam int NUM_COLS = 16;
  localparam int ACC_W    = 32;
  localparam int OUT_W    = 8;
  localparam int KLEN_W   = 16;
  localparam int COL_W    = $clog2(NUM_COLS);

  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, CAPTURE} acc_state_t;
  typedef enum logic {EMPTY, DRAIN} drain_state_t;
endpackage

// File: rtl/acc_drain_requant_sat.sv
// Combinational requantiser: optional ReLU, round-half-up right shift, saturate to OUT_W.
module requant_sat
  import acc_drain_pkg::*;
(
  input  logic [ACC_W-1:0] x,
  input  logic [4:0]       shift_amt,
  input  logic             relu_en,
  output logic [OUT_W-1:0] y
);
  localparam logic signed [ACC_W:0] SAT_HI = {{(ACC_W+1-OUT_W){1'b0}}, OUT_MAX};
  localparam logic signed [ACC_W:0] SAT_LO = {{(ACC_W+1-OUT_W){1'b1}}, OUT_MIN};

  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] shifted;

  always_comb begin
    rnd = '0;
    if (shift_amt != 5'd0) begin
      rnd = {{ACC_W{1'b0}}, 1'b1} << (shift_amt - 5'd1);
    end
    // One extra bit keeps the rounding add from wrapping near the positive limit.
    sum     = $signed({x[ACC_W-1], x}) + rnd;
    shifted = sum >>> shift_amt;
    if (relu_en && x[ACC_W-1]) begin
      y = '0;
    end else if (shifted > SAT_HI) begin
      y = OUT_MAX;
    end else if (shifted < SAT_LO) begin
      y = OUT_MIN;
    end else begin
      y = shifted[OUT_W-1:0];
    end
  end
endmodule

// File: rtl/acc_drain.sv
// Tile beat counter, accumulator clear, column snapshot and requantised drain stream.
//
// acc FSM   | meaning
// IDLE      | waiting for start with non-zero k_len
// ACCUM     | accepting psum beats until count reaches k_len
// CAPTURE   | final beat is in the accumulators; waits for free snapshot
// drain FSM | meaning
// EMPTY     | snapshot holds nothing to send
// DRAIN     | streaming snapshot column col
module acc_drain
  import acc_drain_pkg::*;
(
  input  logic                      clk,
  input  logic                      nRST,
  input  logic                      start,
  input  logic [KLEN_W-1:0]         k_len,
  input  logic [4:0]                shift_amt,
  input  logic                      relu_en,
  input  logic                      psum_valid,
  output logic                      psum_ready,
  input  logic [NUM_COLS*ACC_W-1:0] acc_sum_i,
  output logic                      acc_clear_o,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic [COL_W-1:0]          out_col,
  output logic                      out_last,
  output logic                      busy
);
  acc_state_t   acc_state, acc_next;
  drain_state_t drain_state, drain_next;

  logic [KLEN_W-1:0] cnt, cnt_inc, k_len_q;
  logic [4:0]        shift_q, shift_d;
  logic              relu_q, relu_d;
  logic [COL_W-1:0]  col;
  logic [ACC_W-1:0]  snap [NUM_COLS];
  logic              beat, out_hs, last_hs, cap_fire;
  logic [OUT_W-1:0]  rq_y;

  assign cnt_inc = cnt + KLEN_W'(1);
  assign beat    = psum_valid & psum_ready;
  assign out_hs  = out_valid & out_ready;
  assign last_hs = out_hs & (col == COL_W'(NUM_COLS - 1));
  // Capture may share the cycle with the final drain handshake.
  assign cap_fire = (acc_state == CAPTURE) & ((drain_state == EMPTY) | last_hs);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) acc_state <= IDLE;
    else       acc_state <= acc_next;
  end

  always_comb begin
    acc_next = acc_state;
    case (acc_state)
      IDLE:    if (start && (k_len != '0)) acc_next = ACCUM;
      ACCUM:   if (beat && (cnt_inc == k_len_q)) acc_next = CAPTURE;
      CAPTURE: if (cap_fire) acc_next = IDLE;
      default: acc_next = IDLE;
    endcase
  end

  always_comb begin
    psum_ready  = (acc_state == ACCUM);
    acc_clear_o = cap_fire;
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      cnt     <= '0;
      k_len_q <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
    end else if ((acc_state == IDLE) && start && (k_len != '0)) begin
      cnt     <= '0;
      k_len_q <= k_len;
      shift_q <= shift_amt;
      relu_q  <= relu_en;
    end else if (beat) begin
      cnt <= cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) drain_state <= EMPTY;
    else       drain_state <= drain_next;
  end

  always_comb begin
    drain_next = drain_state;
    case (drain_state)
      EMPTY:   if (cap_fire) drain_next = DRAIN;
      DRAIN:   if (last_hs && !cap_fire) drain_next = EMPTY;
      default: drain_next = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (drain_state == DRAIN);
    out_col   = col;
    out_last  = out_valid & (col == COL_W'(NUM_COLS - 1));
    out_data  = rq_y;
    busy      = (acc_state != IDLE) | (drain_state != EMPTY);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      col     <= '0;
      shift_d <= '0;
      relu_d  <= 1'b0;
      for (int c = 0; c < NUM_COLS; c++) snap[c] <= '0;
    end else if (cap_fire) begin
      col     <= '0;
      shift_d <= shift_q;
      relu_d  <= relu_q;
      for (int c = 0; c < NUM_COLS; c++) snap[c] <= acc_sum_i[c*ACC_W +: ACC_W];
    end else if (out_hs) begin
      col <= col + COL_W'(1);
    end
  end

  requant_sat u_requant (
    .x         (snap[col]),
    .shift_amt (shift_d),
    .relu_en   (relu_d),
    .y         (rq_y)
  );
endmodule

// File: tb/tb_acc_drain.sv
// Randomised bench for acc_drain with external accumulator model and a queue-based output reference.
module tb_acc_drain;
  import acc_drain_pkg::*;

  logic                      clk, nRST, start, relu_en, psum_valid, psum_ready;
  logic [KLEN_W-1:0]         k_len;
  logic [4:0]                shift_amt;
  logic [NUM_COLS*ACC_W-1:0] acc_sum_i;
  logic                      acc_clear_o, out_valid, out_ready, out_last, busy;
  logic [OUT_W-1:0]          out_data;
  logic [COL_W-1:0]          out_col;

  int errors = 0, checks = 0;
  int psum [NUM_COLS];
  int acc  [NUM_COLS];
  int tile_sums [NUM_COLS];
  int got  [NUM_COLS];
  int exp_q[$], exp_col_q[$];
  int ready_mode = 3, clears = 0, n_tiles = 0;
  int pat [4] = '{1, 0, 0, 1};

  acc_drain dut (
    .clk(clk), .nRST(nRST), .start(start), .k_len(k_len), .shift_amt(shift_amt),
    .relu_en(relu_en), .psum_valid(psum_valid), .psum_ready(psum_ready),
    .acc_sum_i(acc_sum_i), .acc_clear_o(acc_clear_o), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_col(out_col),
    .out_last(out_last), .busy(busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // external accumulators: add accepted psum, clear on acc_clear_o, reset on nRST
  always @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int c = 0; c < NUM_COLS; c++) acc[c] <= 0;
    end else begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (acc_clear_o) acc[c] <= 0;
        else if (psum_valid && psum_ready) acc[c] <= acc[c] + psum[c];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_COLS; c++) acc_sum_i[c*ACC_W +: ACC_W] = acc[c];
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // reference requantiser: floor division of the rounded value, then clamp
  function automatic int model_rq(input int x, input int sh, input bit relu);
    longint num, d, q;
    if (relu && x < 0) return 0;
    d   = longint'(1) << sh;
    num = longint'(x) + ((sh != 0) ? d / 2 : 0);
    q   = num / d;
    if ((num % d != 0) && (num < 0)) q = q - 1;
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
    return int'(q);
  endfunction

  initial begin
    int idx = 0;
    out_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1;
        1: begin out_ready = pat[idx % 4][0]; idx++; end
        2: out_ready = ($urandom_range(0, 1) == 1);
        default: out_ready = 0;
      endcase
    end
  end

  always @(negedge clk) if (nRST && acc_clear_o) clears++;

  // output compare against the expected queue, plus stall stability and busy
  initial begin
    bit prev_stall = 0;
    int prev_data = 0, prev_col = 0, e, ec;
    forever begin
      @(negedge clk);
      if (!nRST) begin
        prev_stall = 0;
      end else begin
        chk("busy", busy, exp_q.size() != 0);
        if (prev_stall) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_data", $signed(out_data), prev_data);
          chk("stall_col", out_col, prev_col);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            fail("unexpected_output");
          end else begin
            e  = exp_q.pop_front();
            ec = exp_col_q.pop_front();
            chk("out_data", $signed(out_data), e);
            chk("out_col", out_col, ec);
            chk("out_last", out_last, ec == NUM_COLS - 1);
            got[out_col] = $signed(out_data);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = $signed(out_data);
        prev_col   = out_col;
      end
    end
  end

  task automatic send_tile(input int k, input int sh, input bit relu, input bit ramp, input bit gapless);
    int bv [16][NUM_COLS];
    int run, b, guard;
    for (int c = 0; c < NUM_COLS; c++) begin
      run = 0;
      for (int i = 0; i < k; i++) begin
        if (ramp) bv[i][c] = i + 1;
        else if (i < k - 1) bv[i][c] = int'($urandom_range(0, 2000)) - 1000;
        else bv[i][c] = tile_sums[c] - run;
        run += bv[i][c];
      end
      tile_sums[c] = run;
    end
    @(posedge clk); #1;
    start = 1; k_len = KLEN_W'(k); shift_amt = 5'(sh); relu_en = relu;
    @(posedge clk); #1;
    start = 0;
    n_tiles++;
    for (int c = 0; c < NUM_COLS; c++) begin
      exp_q.push_back(model_rq(tile_sums[c], sh, relu));
      exp_col_q.push_back(c);
    end
    b = 0;
    guard = 0;
    while (b < k && guard < 200) begin
      psum_valid = gapless || ($urandom_range(0, 3) != 0);
      for (int c = 0; c < NUM_COLS; c++) psum[c] = psum_valid ? bv[b][c] : 0;
      @(negedge clk);
      chk("psum_ready_accum", psum_ready, 1);
      if (psum_valid && psum_ready) b++;
      @(posedge clk); #1;
      guard++;
    end
    if (b < k) fail("beats_timeout");
    psum_valid = 0;
    for (int c = 0; c < NUM_COLS; c++) psum[c] = 0;
  endtask

  task automatic wait_clear(input int budget, output int waited);
    waited = 0;
    forever begin
      @(negedge clk);
      chk("psum_ready_capture", psum_ready, 0);
      if (acc_clear_o) break;
      waited++;
      if (waited > budget) begin
        fail("clear_timeout");
        break;
      end
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 || busy) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        fail("drain_timeout");
        break;
      end
    end
  endtask

  task automatic do_reset();
    nRST = 0;
    exp_q.delete();
    exp_col_q.delete();
    repeat (2) @(posedge clk);
    #2 nRST = 1;
  endtask

  initial begin
    int w, found;
    #1_000_000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    bit found;
    nRST = 0; start = 0; k_len = '0; shift_amt = '0; relu_en = 0; psum_valid = 0;
    for (int c = 0; c < NUM_COLS; c++) psum[c] = 0;
    #2;
    chk("rst_psum_ready", psum_ready, 0);
    chk("rst_acc_clear", acc_clear_o, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_col", out_col, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    do_reset();

    // ramp 1..4 on every column, gapless, out_ready held high
    ready_mode = 0;
    send_tile(4, 0, 0, 1, 1);
    wait_clear(50, w);
    chk("clear_latency", w, 0);
    @(negedge clk);
    chk("clear_single_pulse", acc_clear_o, 0);
    chk("first_valid", out_valid, 1);
    chk("first_col", out_col, 0);
    chk("first_data", $signed(out_data), 10);
    wait_drain();
    chk("t1_col0", got[0], 10);
    chk("t1_col15", got[15], 10);
    chk("t1_clears", clears, 1);

    // ReLU and rounding shift
    for (int c = 0; c < NUM_COLS; c++) tile_sums[c] = c * 100 - 800;
    send_tile(3, 4, 1, 0, 0);
    wait_clear(50, w);
    wait_drain();
    chk("relu_col0", got[0], 0);
    chk("relu_col8", got[8], 0);
    chk("round_col9", got[9], 6);
    chk("round_col15", got[15], 44);

    // saturation with random out_ready
    ready_mode = 2;
    for (int c = 0; c < NUM_COLS; c++) tile_sums[c] = int'($urandom_range(0, 400)) - 200;
    tile_sums[0] = 1000; tile_sums[1] = -1000; tile_sums[2] = -129; tile_sums[3] = 127;
    send_tile(2, 0, 0, 0, 0);
    wait_clear(50, w);
    wait_drain();
    chk("sat_pos", got[0], 127);
    chk("sat_neg", got[1], -128);
    chk("sat_m129", got[2], -128);
    chk("sat_127", got[3], 127);

    // ready pattern 1,0,0,1 while draining
    ready_mode = 1;
    for (int c = 0; c < NUM_COLS; c++) tile_sums[c] = int'($urandom_range(0, 20000)) - 10000;
    send_tile(5, 3, 0, 0, 0);
    wait_clear(50, w);
    wait_drain();

    // second tile captured on the last handshake of the first
    ready_mode = 3;
    for (int c = 0; c < NUM_COLS; c++) tile_sums[c] = int'($urandom_range(0, 2000)) - 1000;
    send_tile(3, 1, 0, 0, 0);
    wait_clear(50, w);
    for (int c = 0; c < NUM_COLS; c++) tile_sums[c] = int'($urandom_range(0, 2000)) - 1000;
    send_tile(2, 2, 1, 0, 0);
    repeat (6) begin
      @(negedge clk);
      chk("hold_psum_ready", psum_ready, 0);
      chk("hold_clear", acc_clear_o, 0);
      chk("hold_col", out_col, 0);
    end
    ready_mode = 0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (out_valid && out_ready && out_col == COL_W'(NUM_COLS - 1)) begin
        found = 1;
        chk("capture_on_last_hs", acc_clear_o, 1);
      end else begin
        chk("capture_held", acc_clear_o, 0);
      end
    end
    if (!found) fail("last_hs_timeout");
    @(negedge clk);
    chk("t2_stream_valid", out_valid, 1);
    chk("t2_stream_col", out_col, 0);
    wait_drain();

    // random back-to-back tiles
    ready_mode = 2;
    for (int t = 0; t < 8; t++) begin
      for (int c = 0; c < NUM_COLS; c++)
        tile_sums[c] = ($urandom_range(0, 1) == 1) ? int'($urandom) : int'($urandom_range(0, 8000)) - 4000;
      send_tile(int'($urandom_range(1, 6)), int'($urandom_range(0, 31)), $urandom_range(0, 1) == 1, 0, 0);
      wait_clear(2000, w);
    end
    wait_drain();

    // reset in the middle of a drain
    ready_mode = 0;
    for (int c = 0; c < NUM_COLS; c++) tile_sums[c] = int'($urandom_range(0, 2000)) - 1000;
    send_tile(3, 0, 0, 0, 0);
    wait_clear(50, w);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (out_valid && out_col == COL_W'(7)) found = 1;
    end
    if (!found) fail("col7_timeout");
    #2 nRST = 0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_psum_ready", psum_ready, 0);
    do_reset();
    for (int c = 0; c < NUM_COLS; c++) tile_sums[c] = int'($urandom_range(0, 60000)) - 30000;
    send_tile(4, 5, 0, 0, 0);
    wait_clear(50, w);
    wait_drain();
    chk("clear_count", clears, n_tiles);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
